// File: rtl/mem_arb.sv
//------------------------------------------------------------------------------
// mem_arb
//
// Shares the single SoC data RAM between the instruction-fetch unit (IFU) and
// the load/store unit (LSU). One request is accepted at a time over a
// valid/ready handshake. The arbiter runs the RAM access and then returns a
// one-cycle response pulse to the requester that issued it. When both
// requesters are valid, a round-robin pointer chooses between them, so
// neither one can starve.
//
// Access sequence (RAM_LATENCY = 1):
//   T    handshake (IDLE or RESP)
//   T+1  ACCESS: o_ram_en = 1
//   T+2  WAIT:   i_ram_rdata is sampled at the end of the cycle
//   T+3  RESP:   o_<req>_resp_valid = 1; a new handshake may be taken here
//
// Ports:
//   i_sys_clk, i_sys_rst     clock and asynchronous active-high reset
//   i_ifu_req_valid/o_ifu_req_ready, i_ifu_addr
//                            IFU read request channel
//   o_ifu_resp_valid, o_ifu_rdata
//                            IFU response (one-cycle pulse; data holds)
//   i_lsu_req_valid/o_lsu_req_ready, i_lsu_addr, i_lsu_wen, i_lsu_wmask,
//   i_lsu_wdata              LSU read/write request channel
//   o_lsu_resp_valid, o_lsu_rdata
//                            LSU response (rdata is 0 for writes)
//   o_ram_en, o_ram_wen, o_ram_wmask, o_ram_addr, o_ram_wdata, i_ram_rdata
//                            RAM port; all o_ram_* are 0 outside ACCESS
//------------------------------------------------------------------------------
module mem_arb #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int RAM_LATENCY = 1
) (
  input  logic                    i_sys_clk,
  input  logic                    i_sys_rst,

  input  logic                    i_ifu_req_valid,
  output logic                    o_ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   i_ifu_addr,
  output logic                    o_ifu_resp_valid,
  output logic [DATA_WIDTH-1:0]   o_ifu_rdata,

  input  logic                    i_lsu_req_valid,
  output logic                    o_lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   i_lsu_addr,
  input  logic                    i_lsu_wen,
  input  logic [DATA_WIDTH/8-1:0] i_lsu_wmask,
  input  logic [DATA_WIDTH-1:0]   i_lsu_wdata,
  output logic                    o_lsu_resp_valid,
  output logic [DATA_WIDTH-1:0]   o_lsu_rdata,

  output logic                    o_ram_en,
  output logic                    o_ram_wen,
  output logic [DATA_WIDTH/8-1:0] o_ram_wmask,
  output logic [ADDR_WIDTH-1:0]   o_ram_addr,
  output logic [DATA_WIDTH-1:0]   o_ram_wdata,
  input  logic [DATA_WIDTH-1:0]   i_ram_rdata
);

  localparam int MASK_W = DATA_WIDTH / 8;
  localparam int CNT_W  = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RAM_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  typedef enum logic {
    REQ_IFU = 1'b0,
    REQ_LSU = 1'b1
  } req_t;

  state_t                 state;
  state_t                 state_nx;
  req_t                   ptr;        // requester that wins when both are valid
  req_t                   owner;      // requester of the access in flight
  logic [CNT_W-1:0]       cnt;

  logic [ADDR_WIDTH-1:0]  cap_addr;
  logic                   cap_wen;
  logic [MASK_W-1:0]      cap_wmask;
  logic [DATA_WIDTH-1:0]  cap_wdata;

  logic                   accept_window;
  logic                   grant_ifu;
  logic                   grant_lsu;
  logic                   hs_ifu;
  logic                   hs_lsu;
  logic                   hs;
  logic                   wait_done;
  logic [DATA_WIDTH-1:0]  sample_data;

  //----------------------------------------------------------------------------
  // Grant and handshake
  //----------------------------------------------------------------------------
  // A request can be accepted only while no access is in flight (IDLE) or in
  // the response cycle of the previous access (RESP). The grant is driven only
  // to the single chosen requester. Ready is also masked while reset is
  // asserted, so that every output reads 0 during reset.
  always_comb begin
    accept_window = ((state == S_IDLE) || (state == S_RESP)) && !i_sys_rst;
    grant_lsu     = i_lsu_req_valid && (!i_ifu_req_valid || (ptr == REQ_LSU));
    grant_ifu     = i_ifu_req_valid && (!i_lsu_req_valid || (ptr == REQ_IFU));
    hs_lsu        = accept_window && grant_lsu;
    hs_ifu        = accept_window && grant_ifu;
    hs            = hs_lsu || hs_ifu;
    wait_done     = (state == S_WAIT) && (cnt == '0);
    // A write acknowledgement always returns 0 as its data.
    sample_data   = cap_wen ? '0 : i_ram_rdata;
  end

  //----------------------------------------------------------------------------
  // FSM state register
  //----------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so that every
  // flop samples the values from before the edge, whatever order the blocks
  // are evaluated in.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  //----------------------------------------------------------------------------
  // FSM next state and outputs
  //----------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first. A path that does not
  // assign a signal would otherwise infer a latch.
  always_comb begin
    state_nx         = state;
    o_ifu_req_ready  = hs_ifu;
    o_lsu_req_ready  = hs_lsu;
    o_ifu_resp_valid = 1'b0;
    o_lsu_resp_valid = 1'b0;
    o_ram_en         = 1'b0;
    o_ram_wen        = 1'b0;
    o_ram_wmask      = '0;
    o_ram_addr       = '0;
    o_ram_wdata      = '0;

    case (state)
      S_IDLE: begin
        if (hs) begin
          state_nx = S_ACCESS;
        end
      end

      S_ACCESS: begin
        o_ram_en   = 1'b1;
        o_ram_addr = cap_addr;
        // For a read, the write-side RAM signals stay 0.
        if (cap_wen) begin
          o_ram_wen   = 1'b1;
          o_ram_wmask = cap_wmask;
          o_ram_wdata = cap_wdata;
        end
        state_nx = S_WAIT;
      end

      S_WAIT: begin
        if (cnt == '0) begin
          state_nx = S_RESP;
        end
      end

      S_RESP: begin
        o_ifu_resp_valid = (owner == REQ_IFU);
        o_lsu_resp_valid = (owner == REQ_LSU);
        state_nx         = hs ? S_ACCESS : S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  //----------------------------------------------------------------------------
  // Request capture, round-robin pointer, latency counter, response data
  //----------------------------------------------------------------------------
  // NOTE: the capture and data registers are reset as well, because the
  // outputs must read 0 from reset until the first response.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      ptr         <= REQ_LSU;
      owner       <= REQ_IFU;
      cnt         <= '0;
      cap_addr    <= '0;
      cap_wen     <= 1'b0;
      cap_wmask   <= '0;
      cap_wdata   <= '0;
      o_ifu_rdata <= '0;
      o_lsu_rdata <= '0;
    end else begin
      if (hs) begin
        // After each grant the pointer moves to the requester that was not
        // served. IFU requests are always captured as plain reads.
        owner     <= hs_lsu ? REQ_LSU : REQ_IFU;
        ptr       <= hs_lsu ? REQ_IFU : REQ_LSU;
        cap_addr  <= hs_lsu ? i_lsu_addr : i_ifu_addr;
        cap_wen   <= hs_lsu && i_lsu_wen;
        cap_wmask <= hs_lsu ? i_lsu_wmask : '0;
        cap_wdata <= hs_lsu ? i_lsu_wdata : '0;
      end

      if (state == S_ACCESS) begin
        cnt <= CNT_LOAD;
      end else if ((state == S_WAIT) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end

      // Only the owner's data register is loaded. The other requester keeps
      // its last response data.
      if (wait_done) begin
        if (owner == REQ_LSU) begin
          o_lsu_rdata <= sample_data;
        end else begin
          o_ifu_rdata <= sample_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
//------------------------------------------------------------------------------
// tb_mem_arb
//
// Two arbiter instances share one clock and one reset:
//   index 0: RAM_LATENCY = 1
//   index 1: RAM_LATENCY = 3
// Each instance has its own behavioural RAM.
//
// A transaction-level scoreboard predicts every output on every cycle from
// three pieces of state: whether an access is outstanding, how many cycles
// have passed since its handshake, and the round-robin pointer. Directed
// stimulus adds hand-computed literal expectations for the scenarios below.
//------------------------------------------------------------------------------
module tb_mem_arb;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic          ifu_valid [2];
  logic          ifu_ready [2];
  logic [AW-1:0] ifu_addr  [2];
  logic          ifu_resp  [2];
  logic [DW-1:0] ifu_rdata [2];
  logic          lsu_valid [2];
  logic          lsu_ready [2];
  logic [AW-1:0] lsu_addr  [2];
  logic          lsu_wen   [2];
  logic [MW-1:0] lsu_wmask [2];
  logic [DW-1:0] lsu_wdata [2];
  logic          lsu_resp  [2];
  logic [DW-1:0] lsu_rdata [2];
  logic          ram_en    [2];
  logic          ram_wen   [2];
  logic [MW-1:0] ram_wmask [2];
  logic [AW-1:0] ram_addr  [2];
  logic [DW-1:0] ram_wdata [2];
  logic [DW-1:0] ram_rdata [2];

  int checks = 0;
  int errors = 0;

  mem_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_LATENCY(1)) dut (
    .i_sys_clk(clk), .i_sys_rst(rst),
    .i_ifu_req_valid(ifu_valid[0]), .o_ifu_req_ready(ifu_ready[0]),
    .i_ifu_addr(ifu_addr[0]), .o_ifu_resp_valid(ifu_resp[0]),
    .o_ifu_rdata(ifu_rdata[0]),
    .i_lsu_req_valid(lsu_valid[0]), .o_lsu_req_ready(lsu_ready[0]),
    .i_lsu_addr(lsu_addr[0]), .i_lsu_wen(lsu_wen[0]),
    .i_lsu_wmask(lsu_wmask[0]), .i_lsu_wdata(lsu_wdata[0]),
    .o_lsu_resp_valid(lsu_resp[0]), .o_lsu_rdata(lsu_rdata[0]),
    .o_ram_en(ram_en[0]), .o_ram_wen(ram_wen[0]), .o_ram_wmask(ram_wmask[0]),
    .o_ram_addr(ram_addr[0]), .o_ram_wdata(ram_wdata[0]),
    .i_ram_rdata(ram_rdata[0])
  );

  mem_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_LATENCY(3)) dut3 (
    .i_sys_clk(clk), .i_sys_rst(rst),
    .i_ifu_req_valid(ifu_valid[1]), .o_ifu_req_ready(ifu_ready[1]),
    .i_ifu_addr(ifu_addr[1]), .o_ifu_resp_valid(ifu_resp[1]),
    .o_ifu_rdata(ifu_rdata[1]),
    .i_lsu_req_valid(lsu_valid[1]), .o_lsu_req_ready(lsu_ready[1]),
    .i_lsu_addr(lsu_addr[1]), .i_lsu_wen(lsu_wen[1]),
    .i_lsu_wmask(lsu_wmask[1]), .i_lsu_wdata(lsu_wdata[1]),
    .o_lsu_resp_valid(lsu_resp[1]), .o_lsu_rdata(lsu_rdata[1]),
    .o_ram_en(ram_en[1]), .o_ram_wen(ram_wen[1]), .o_ram_wmask(ram_wmask[1]),
    .o_ram_addr(ram_addr[1]), .o_ram_wdata(ram_wdata[1]),
    .i_ram_rdata(ram_rdata[1])
  );

  //----------------------------------------------------------------------------
  // Helpers
  //----------------------------------------------------------------------------
  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Initial RAM contents: word 4 (address 0x10) holds DEADBEEF; every other
  // word follows a simple arithmetic pattern.
  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0]  m);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  //----------------------------------------------------------------------------
  // Behavioural RAMs. Read data appears lat_of(d) cycles after the o_ram_en
  // cycle and reads BAD0BAD0 at every other time. Contents revert to
  // init_word() whenever reset is asserted.
  //----------------------------------------------------------------------------
  logic [31:0] ram_mem [2][64];
  logic [31:0] rd_pipe [2][3];
  logic [2:0]  rv_pipe [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int i = 0; i < 64; i++) ram_mem[d][i] <= init_word(i);
        rv_pipe[d] <= 3'b000;
      end else begin
        if (ram_en[d] && ram_wen[d])
          ram_mem[d][ram_addr[d][7:2]] <= merge(ram_mem[d][ram_addr[d][7:2]],
                                                ram_wdata[d], ram_wmask[d]);
        rd_pipe[d][0] <= ram_mem[d][ram_addr[d][7:2]];
        rd_pipe[d][1] <= rd_pipe[d][0];
        rd_pipe[d][2] <= rd_pipe[d][1];
        rv_pipe[d]    <= {rv_pipe[d][1:0], ram_en[d] && !ram_wen[d]};
      end
    end
  end

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      ram_rdata[d] = rv_pipe[d][lat_of(d)-1] ? rd_pipe[d][lat_of(d)-1]
                                             : 32'hBAD0_BAD0;
    end
  end

  //----------------------------------------------------------------------------
  // Scoreboard. Each negedge it predicts the outputs of the current cycle from
  // the outstanding access (age k counted from its handshake) and then
  // advances to the next cycle.
  //   ram_en is expected at k == 1; the response at k == 2 + latency.
  //   A new request can be granted when nothing is outstanding, or in the
  //   response cycle of the current access.
  //----------------------------------------------------------------------------
  bit          m_busy  [2];
  int          m_k     [2];
  bit          m_owner [2];   // 1 = LSU
  bit          m_ptr   [2];   // 1 = LSU has priority
  logic [31:0] m_addr  [2];
  bit          m_wen   [2];
  logic [3:0]  m_wmask [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_data  [2];
  logic [31:0] m_hold_ifu [2];
  logic [31:0] m_hold_lsu [2];
  logic [31:0] ref_mem [2][64];

  task automatic model_step(input int d);
    int  last;
    bit  ok, er_l, er_i, exp_en, exp_ri, exp_rl;
    string p;
    p    = $sformatf("d%0d ", d);
    last = 2 + lat_of(d);
    if (rst) begin
      check({p, "rst ifu_ready"}, ifu_ready[d], 0);
      check({p, "rst lsu_ready"}, lsu_ready[d], 0);
      check({p, "rst ram_en"},    ram_en[d],    0);
      check({p, "rst ifu_resp"},  ifu_resp[d],  0);
      check({p, "rst lsu_resp"},  lsu_resp[d],  0);
      check({p, "rst ifu_rdata"}, ifu_rdata[d], 0);
      check({p, "rst lsu_rdata"}, lsu_rdata[d], 0);
      m_busy[d]     = 0;
      m_k[d]        = 0;
      m_ptr[d]      = 1;
      m_hold_ifu[d] = 0;
      m_hold_lsu[d] = 0;
      for (int i = 0; i < 64; i++) ref_mem[d][i] = init_word(i);
      return;
    end

    ok   = !m_busy[d] || (m_k[d] == last);
    er_l = ok && lsu_valid[d] && (!ifu_valid[d] || m_ptr[d]);
    er_i = ok && ifu_valid[d] && (!lsu_valid[d] || !m_ptr[d]);
    check({p, "ifu_ready"}, ifu_ready[d], er_i);
    check({p, "lsu_ready"}, lsu_ready[d], er_l);

    exp_en = m_busy[d] && (m_k[d] == 1);
    check({p, "ram_en"}, ram_en[d], exp_en);
    if (exp_en) begin
      check({p, "ram_addr"},  ram_addr[d],  m_addr[d]);
      check({p, "ram_wen"},   ram_wen[d],   m_wen[d]);
      check({p, "ram_wmask"}, ram_wmask[d], m_wen[d] ? m_wmask[d] : 4'h0);
      check({p, "ram_wdata"}, ram_wdata[d], m_wen[d] ? m_wdata[d] : 32'h0);
      if (m_wen[d]) begin
        ref_mem[d][m_addr[d][7:2]] = merge(ref_mem[d][m_addr[d][7:2]],
                                           m_wdata[d], m_wmask[d]);
        m_data[d] = 32'h0;
      end else begin
        m_data[d] = ref_mem[d][m_addr[d][7:2]];
      end
    end

    exp_ri = m_busy[d] && (m_k[d] == last) && !m_owner[d];
    exp_rl = m_busy[d] && (m_k[d] == last) &&  m_owner[d];
    if (exp_ri) m_hold_ifu[d] = m_data[d];
    if (exp_rl) m_hold_lsu[d] = m_data[d];
    check({p, "ifu_resp"},  ifu_resp[d],  exp_ri);
    check({p, "lsu_resp"},  lsu_resp[d],  exp_rl);
    check({p, "ifu_rdata"}, ifu_rdata[d], m_hold_ifu[d]);
    check({p, "lsu_rdata"}, lsu_rdata[d], m_hold_lsu[d]);

    if (er_l || er_i) begin
      m_busy[d]  = 1;
      m_k[d]     = 1;
      m_owner[d] = er_l;
      m_ptr[d]   = !er_l;
      m_addr[d]  = er_l ? lsu_addr[d] : ifu_addr[d];
      m_wen[d]   = er_l && lsu_wen[d];
      m_wmask[d] = lsu_wmask[d];
      m_wdata[d] = lsu_wdata[d];
    end else if (m_busy[d]) begin
      if (m_k[d] == last) m_busy[d] = 0;
      else                m_k[d]++;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) model_step(d);
    end
  end

  //----------------------------------------------------------------------------
  // Directed stimulus. Inputs change 1 ns after posedge; literal checks sample
  // at negedge.
  //----------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_cnt;
    int ifu_seen;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      ifu_valid[d] = 0; ifu_addr[d] = '0;
      lsu_valid[d] = 0; lsu_addr[d] = '0; lsu_wen[d] = 0;
      lsu_wmask[d] = '0; lsu_wdata[d] = '0;
    end

    // 1: IFU read of 0x10 straight after reset release
    apply_reset();
    check("t1 ram_en idle", ram_en[0], 0);
    ifu_valid[0] = 1; ifu_addr[0] = 32'h0000_0010;
    @(negedge clk); check("t1 ifu_ready", ifu_ready[0], 1);
    next_cycle(); ifu_valid[0] = 0; ifu_addr[0] = 32'hFFFF_FFF0;
    @(negedge clk);
    check("t1 ram_en T+1", ram_en[0], 1);
    check("t1 ram_addr", ram_addr[0], 32'h10);
    check("t1 ram_wen", ram_wen[0], 0);
    next_cycle(); @(negedge clk); check("t1 ram_en T+2", ram_en[0], 0);
    next_cycle(); @(negedge clk);
    check("t1 ifu_resp T+3", ifu_resp[0], 1);
    check("t1 ifu_rdata", ifu_rdata[0], 32'hDEAD_BEEF);
    check("t1 lsu_resp", lsu_resp[0], 0);
    next_cycle(); @(negedge clk);
    check("t1 ifu_resp T+4", ifu_resp[0], 0);
    check("t1 ifu_rdata hold", ifu_rdata[0], 32'hDEAD_BEEF);
    next_cycle();

    // 2: both requesters held valid after reset; grants go LSU, IFU, LSU, IFU
    apply_reset();
    ifu_valid[0] = 1; ifu_addr[0] = 32'h30;
    lsu_valid[0] = 1; lsu_addr[0] = 32'h20; lsu_wen[0] = 0;
    lsu_wmask[0] = 4'hF; lsu_wdata[0] = 32'h5555_5555;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("t2 c%0d lsu_ready", c), lsu_ready[0], (c == 0) || (c == 6));
      check($sformatf("t2 c%0d ifu_ready", c), ifu_ready[0], (c == 3) || (c == 9));
      next_cycle();
    end
    ifu_valid[0] = 0; lsu_valid[0] = 0;
    repeat (4) next_cycle();

    // 3: LSU masked write, read-back of the merged word, zero-mask write
    lsu_valid[0] = 1; lsu_addr[0] = 32'h40; lsu_wen[0] = 1;
    lsu_wdata[0] = 32'h1234_5678; lsu_wmask[0] = 4'b0011;
    @(negedge clk); check("t3 lsu_ready", lsu_ready[0], 1);
    next_cycle(); lsu_valid[0] = 0; lsu_wen[0] = 0; lsu_wdata[0] = '0; lsu_wmask[0] = '0;
    @(negedge clk);
    check("t3 ram_en", ram_en[0], 1);
    check("t3 ram_wen", ram_wen[0], 1);
    check("t3 ram_wmask", ram_wmask[0], 4'b0011);
    check("t3 ram_wdata", ram_wdata[0], 32'h1234_5678);
    check("t3 ram_addr", ram_addr[0], 32'h40);
    next_cycle(); next_cycle(); @(negedge clk);
    check("t3 lsu_resp", lsu_resp[0], 1);
    check("t3 lsu_rdata", lsu_rdata[0], 0);
    check("t3 ifu_resp", ifu_resp[0], 0);
    next_cycle();

    ifu_valid[0] = 1; ifu_addr[0] = 32'h40;
    next_cycle(); ifu_valid[0] = 0;
    next_cycle(); next_cycle(); @(negedge clk);
    check("t3 readback resp", ifu_resp[0], 1);
    check("t3 readback data", ifu_rdata[0], 32'h1010_5678);
    next_cycle();

    lsu_valid[0] = 1; lsu_addr[0] = 32'h44; lsu_wen[0] = 1;
    lsu_wdata[0] = 32'hFFFF_FFFF; lsu_wmask[0] = 4'b0000;
    next_cycle(); lsu_valid[0] = 0; lsu_wen[0] = 0;
    @(negedge clk);
    check("t3 mask0 ram_en", ram_en[0], 1);
    check("t3 mask0 ram_wmask", ram_wmask[0], 4'b0000);
    next_cycle(); next_cycle(); @(negedge clk);
    check("t3 mask0 ack", lsu_resp[0], 1);
    next_cycle();

    lsu_valid[0] = 1; lsu_addr[0] = 32'h44; lsu_wen[0] = 0;
    next_cycle(); lsu_valid[0] = 0;
    next_cycle(); next_cycle(); @(negedge clk);
    check("t3 mask0 readback", lsu_rdata[0], 32'h1011_2233);
    next_cycle();

    // 4: RAM_LATENCY = 3 instance, LSU read of 0x10
    lsu_valid[1] = 1; lsu_addr[1] = 32'h10; lsu_wen[1] = 0;
    @(negedge clk); check("t4 lsu_ready", lsu_ready[1], 1);
    next_cycle(); lsu_valid[1] = 0;
    @(negedge clk); check("t4 ram_en T+1", ram_en[1], 1);
    for (int c = 2; c <= 5; c++) begin
      next_cycle(); @(negedge clk);
      check($sformatf("t4 ram_en T+%0d", c), ram_en[1], 0);
      check($sformatf("t4 lsu_resp T+%0d", c), lsu_resp[1], (c == 5));
    end
    check("t4 lsu_rdata", lsu_rdata[1], 32'hDEAD_BEEF);
    next_cycle();

    // 5: reset during WAIT of an IFU read; afterwards LSU has priority again
    ifu_valid[0] = 1; ifu_addr[0] = 32'h10;
    next_cycle(); ifu_valid[0] = 0;
    next_cycle();
    #2 rst = 1'b1;
    #1;
    check("t5 rst ram_en", ram_en[0], 0);
    check("t5 rst ifu_resp", ifu_resp[0], 0);
    check("t5 rst ifu_rdata", ifu_rdata[0], 0);
    check("t5 rst lsu_rdata", lsu_rdata[0], 0);
    check("t5 rst ready", {ifu_ready[0], lsu_ready[0]}, 0);
    next_cycle(); next_cycle();
    rst = 1'b0;
    ifu_valid[0] = 1; ifu_addr[0] = 32'h30;
    lsu_valid[0] = 1; lsu_addr[0] = 32'h20; lsu_wen[0] = 0;
    @(negedge clk);
    check("t5 lsu_ready", lsu_ready[0], 1);
    check("t5 ifu_ready", ifu_ready[0], 0);
    next_cycle(); ifu_valid[0] = 0; lsu_valid[0] = 0;
    ifu_seen = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (ifu_resp[0]) ifu_seen++;
      if (c < 3) next_cycle();
    end
    check("t5 no ifu_resp", ifu_seen, 0);
    check("t5 lsu_resp", lsu_resp[0], 1);
    check("t5 lsu_rdata", lsu_rdata[0], 32'h1008_1018);
    next_cycle();

    // 6: IFU pulses valid for one cycle while an LSU read is in flight
    lsu_valid[0] = 1; lsu_addr[0] = 32'h10; lsu_wen[0] = 0;
    next_cycle(); lsu_valid[0] = 0;
    ifu_valid[0] = 1; ifu_addr[0] = 32'h10;
    @(negedge clk);
    check("t6 ifu_ready in ACCESS", ifu_ready[0], 0);
    en_cnt = ram_en[0] ? 1 : 0;
    ifu_seen = 0;
    next_cycle(); ifu_valid[0] = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ram_en[0]) en_cnt++;
      if (ifu_resp[0]) ifu_seen++;
      next_cycle();
    end
    check("t6 ram_en pulses", en_cnt, 1);
    check("t6 ifu_resp count", ifu_seen, 0);

    repeat (2) next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
